// File: rtl/rptr_empty_fwft_if.sv
// Read-side bus of the dual-clock FIFO read controller.
// Groups the synchronized write pointer, the memory read port and the
// consumer-facing FWFT handshake/status signals.
//   master : the read controller (drives ren/raddr/rptr/status/data out)
//   slave  : the environment (synchronizer, memory, consumer)
interface rptr_empty_fwft_if #(
    parameter int ADDRSIZE = 8,
    parameter int DSIZE    = 8
) ();
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [DSIZE-1:0]    rdata_mem;
    logic                rinc;
    logic                ren;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                rvalid;
    logic [DSIZE-1:0]    rdata;
    logic [ADDRSIZE:0]   rlevel;
    logic                ralmost_empty;

    modport master (
        input  rq2_wptr, rdata_mem, rinc,
        output ren, raddr, rptr, rempty, rvalid, rdata, rlevel, ralmost_empty
    );

    modport slave (
        output rq2_wptr, rdata_mem, rinc,
        input  ren, raddr, rptr, rempty, rvalid, rdata, rlevel, ralmost_empty
    );
endinterface

// File: rtl/rptr_empty_fwft.sv
// Read-side controller of the dual-clock FIFO.
// Owns the binary/Gray read pointers, the registered empty flag and the
// read-domain occupancy, and issues reads to a synchronous-read memory.
// A two-entry first-word-fall-through buffer (head/skid) hides the one-cycle
// memory latency so the consumer sees the head word in rdata while rvalid=1.
// Ports:
//   rclk   : read clock
//   rrst_n : synchronous active-low reset
//   bus    : rptr_empty_fwft_if.master
//            in : rq2_wptr (synced Gray wptr), rdata_mem, rinc (pop)
//            out: ren, raddr, rptr, rempty, rvalid, rdata, rlevel,
//                 ralmost_empty
module rptr_empty_fwft #(
    parameter int ADDRSIZE = 8,
    parameter int DSIZE    = 8,
    parameter int AE_LEVEL = 4
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    rptr_empty_fwft_if.master      bus
);
    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0]    rbin_q, rptr_q, rlevel_q;
    logic             rempty_q, ralmost_empty_q, inflt_q, rvalid_q;
    logic [1:0]       ocnt_q;
    logic [DSIZE-1:0] head_q, skid_q;

    logic             pop, ren;
    logic [2:0]       pend;
    logic [PW-1:0]    rbin_d, rgray_d, wbin_s, level_d;
    logic [1:0]       ocnt_d;
    logic [DSIZE-1:0] head_d, skid_d;

    always_comb begin
        pop  = bus.rinc & rvalid_q;
        // Entries held after this edge, counting the word already in flight.
        // pop implies ocnt_q>0, so this never underflows.
        pend = {1'b0, ocnt_q} + {2'b00, inflt_q} - {2'b00, pop};
        // Only issue a read when a buffer slot is guaranteed for its data.
        ren  = ~rempty_q & (pend < 3'd2);

        rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, ren};
        rgray_d = (rbin_d >> 1) ^ rbin_d;

        // Gray to binary: each bit is the XOR of itself and all higher bits.
        wbin_s = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            wbin_s[i] = ^(bus.rq2_wptr >> i);
        end
        level_d = wbin_s - rbin_d;

        ocnt_d = pend[1:0];
        head_d = head_q;
        skid_d = skid_q;
        if (pop && ocnt_q == 2'd2) begin
            head_d = skid_q;
        end
        // Returning word lands in the first slot free after the pop.
        if (inflt_q) begin
            if (ocnt_q == 2'd0 || (ocnt_q == 2'd1 && pop)) begin
                head_d = bus.rdata_mem;
            end else begin
                skid_d = bus.rdata_mem;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            rempty_q        <= 1'b1;
            rlevel_q        <= '0;
            ralmost_empty_q <= 1'b1;
            ocnt_q          <= '0;
            inflt_q         <= 1'b0;
            rvalid_q        <= 1'b0;
            head_q          <= '0;
            skid_q          <= '0;
        end else begin
            rbin_q          <= rbin_d;
            rptr_q          <= rgray_d;
            rempty_q        <= (rgray_d == bus.rq2_wptr);
            rlevel_q        <= level_d;
            ralmost_empty_q <= (level_d <= PW'(AE_LEVEL));
            ocnt_q          <= ocnt_d;
            inflt_q         <= ren;
            rvalid_q        <= (ocnt_d != 2'd0);
            head_q          <= head_d;
            skid_q          <= skid_d;
        end
    end

    assign bus.ren           = ren;
    assign bus.raddr         = rbin_q[ADDRSIZE-1:0];
    assign bus.rptr          = rptr_q;
    assign bus.rempty        = rempty_q;
    assign bus.rvalid        = rvalid_q;
    assign bus.rdata         = head_q;
    assign bus.rlevel        = rlevel_q;
    assign bus.ralmost_empty = ralmost_empty_q;
endmodule

// File: tb/tb_rptr_empty_fwft.sv
module tb_rptr_empty_fwft;
    logic rclk;
    logic rrst_n;
    logic [7:0] mem [256];
    int unsigned vectors;
    int unsigned miscompares;
    int unsigned wtot;   // words the writer has made visible
    int unsigned pidx;   // words popped so far (next expected word index)

    rptr_empty_fwft_if #(.ADDRSIZE(8), .DSIZE(8)) bus ();

    rptr_empty_fwft #(.ADDRSIZE(8), .DSIZE(8), .AE_LEVEL(4)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Synchronous-read memory: contents fixed per address.
    always @(posedge rclk) begin
        if (bus.ren) bus.rdata_mem <= mem[bus.raddr];
    end

    function automatic logic [8:0] gray(input logic [8:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick;
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic set_w(input int unsigned w);
        wtot = w;
        bus.rq2_wptr = gray(w[8:0]);
    endtask

    task automatic test_reset;
        rrst_n = 1'b0;
        bus.rinc = 1'b0;
        repeat (3) begin
            bus.rq2_wptr = 9'($urandom);
            tick();
        end
        vectors++; if (bus.rempty !== 1'b1) begin miscompares++; $display("FAIL reset_rempty: got %0b expected 1", bus.rempty); end
        vectors++; if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %0b expected 0", bus.rvalid); end
        vectors++; if (bus.ren !== 1'b0) begin miscompares++; $display("FAIL reset_ren: got %0b expected 0", bus.ren); end
        vectors++; if (bus.rptr !== 9'h0) begin miscompares++; $display("FAIL reset_rptr: got %0h expected 0", bus.rptr); end
        vectors++; if (bus.rlevel !== 9'h0) begin miscompares++; $display("FAIL reset_rlevel: got %0h expected 0", bus.rlevel); end
        vectors++; if (bus.ralmost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_ae: got %0b expected 1", bus.ralmost_empty); end
        vectors++; if (bus.raddr !== 8'h0) begin miscompares++; $display("FAIL reset_raddr: got %0h expected 0", bus.raddr); end
        vectors++; if (bus.rdata !== 8'h0) begin miscompares++; $display("FAIL reset_rdata: got %0h expected 0", bus.rdata); end
        set_w(0);
        pidx = 0;
        tick();
        rrst_n = 1'b1;
        tick();
        vectors++; if (bus.rempty !== 1'b1) begin miscompares++; $display("FAIL idle_rempty: got %0b expected 1", bus.rempty); end
    endtask

    task automatic test_single;
        set_w(1);
        tick(); // T1
        vectors++; if (bus.rempty !== 1'b0) begin miscompares++; $display("FAIL single_rempty_t1: got %0b expected 0", bus.rempty); end
        vectors++; if (bus.ren !== 1'b1 || bus.raddr !== 8'h0) begin miscompares++; $display("FAIL single_ren_t2: got ren=%0b raddr=%0h expected ren=1 raddr=0", bus.ren, bus.raddr); end
        vectors++; if (bus.rlevel !== 9'd1) begin miscompares++; $display("FAIL single_rlevel: got %0d expected 1", bus.rlevel); end
        tick(); // T2
        vectors++; if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL single_rvalid_t2: got %0b expected 0", bus.rvalid); end
        tick(); // T3
        vectors++; if (bus.rvalid !== 1'b1 || bus.rdata !== mem[0]) begin miscompares++; $display("FAIL single_data_t3: got v=%0b d=%0h expected v=1 d=%0h", bus.rvalid, bus.rdata, mem[0]); end
        vectors++; if (bus.rempty !== 1'b1 || bus.ren !== 1'b0) begin miscompares++; $display("FAIL single_last: got rempty=%0b ren=%0b expected 1 0", bus.rempty, bus.ren); end
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        pidx = 1;
        vectors++; if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL single_pop_rvalid: got %0b expected 0", bus.rvalid); end
        vectors++; if (bus.rptr !== 9'h001 || bus.rempty !== 1'b1) begin miscompares++; $display("FAIL single_pop_ptr: got rptr=%0h rempty=%0b expected 001 1", bus.rptr, bus.rempty); end
    endtask

    task automatic test_stream_wrap;
        logic started;
        logic [7:0] a;
        started = 1'b0;
        bus.rinc = 1'b1;
        for (int cyc = 0; cyc < 800 && pidx < 601; cyc++) begin
            if (bus.rvalid) begin
                started = 1'b1;
                a = pidx[7:0];
                vectors++; if (bus.rdata !== mem[a]) begin miscompares++; $display("FAIL stream_data[%0d]: got %0h expected %0h", pidx, bus.rdata, mem[a]); end
                pidx++;
            end else if (started) begin
                vectors++; miscompares++;
                $display("FAIL stream_bubble[%0d]: got rvalid=0 expected 1", pidx);
            end
            set_w(pidx + 100);
            tick();
        end
        vectors++; if (pidx != 601) begin miscompares++; $display("FAIL stream_count: got %0d expected 601", pidx); end
    endtask

    task automatic test_drain;
        logic [7:0] a;
        bus.rinc = 1'b1;
        for (int cyc = 0; cyc < 400 && pidx != wtot; cyc++) begin
            if (bus.rvalid) begin
                a = pidx[7:0];
                vectors++; if (bus.rdata !== mem[a]) begin miscompares++; $display("FAIL drain_data[%0d]: got %0h expected %0h", pidx, bus.rdata, mem[a]); end
                pidx++;
            end
            tick();
        end
        repeat (3) tick();
        vectors++; if (pidx != wtot) begin miscompares++; $display("FAIL drain_count: got %0d expected %0d", pidx, wtot); end
        vectors++; if (bus.rvalid !== 1'b0 || bus.rempty !== 1'b1) begin miscompares++; $display("FAIL drain_flags: got rvalid=%0b rempty=%0b expected 0 1", bus.rvalid, bus.rempty); end
        vectors++; if (bus.rlevel !== 9'h0 || bus.ralmost_empty !== 1'b1) begin miscompares++; $display("FAIL drain_level: got %0d ae=%0b expected 0 1", bus.rlevel, bus.ralmost_empty); end
        vectors++; if (bus.rptr !== gray(wtot[8:0])) begin miscompares++; $display("FAIL drain_rptr: got %0h expected %0h", bus.rptr, gray(wtot[8:0])); end
    endtask

    task automatic test_stall;
        int unsigned b;
        logic [7:0] a;
        bus.rinc = 1'b0;
        set_w(wtot + 10);
        repeat (6) tick();
        b = pidx + 2;
        a = pidx[7:0];
        vectors++; if (bus.rvalid !== 1'b1 || bus.rdata !== mem[a]) begin miscompares++; $display("FAIL stall_head: got v=%0b d=%0h expected v=1 d=%0h", bus.rvalid, bus.rdata, mem[a]); end
        vectors++; if (bus.ren !== 1'b0) begin miscompares++; $display("FAIL stall_ren: got %0b expected 0", bus.ren); end
        vectors++; if (bus.rptr !== gray(b[8:0])) begin miscompares++; $display("FAIL stall_rptr: got %0h expected %0h", bus.rptr, gray(b[8:0])); end
        bus.rinc = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a = pidx[7:0];
            vectors++; if (bus.rvalid !== 1'b1 || bus.rdata !== mem[a]) begin miscompares++; $display("FAIL stall_out[%0d]: got v=%0b d=%0h expected v=1 d=%0h", k, bus.rvalid, bus.rdata, mem[a]); end
            pidx++;
            tick();
        end
        vectors++; if (bus.rvalid !== 1'b0 || bus.rempty !== 1'b1) begin miscompares++; $display("FAIL stall_end: got rvalid=%0b rempty=%0b expected 0 1", bus.rvalid, bus.rempty); end
    endtask

    task automatic test_pop_empty;
        int unsigned last;
        logic [7:0] a;
        last = pidx - 1;
        a = last[7:0];
        bus.rinc = 1'b1;
        repeat (3) begin
            tick();
            vectors++; if (bus.rvalid !== 1'b0 || bus.rptr !== gray(wtot[8:0]) || bus.raddr !== wtot[7:0] || bus.rdata !== mem[a]) begin
                miscompares++;
                $display("FAIL pop_empty: got v=%0b rptr=%0h raddr=%0h d=%0h expected v=0 rptr=%0h raddr=%0h d=%0h", bus.rvalid, bus.rptr, bus.raddr, bus.rdata, gray(wtot[8:0]), wtot[7:0], mem[a]);
            end
        end
        bus.rinc = 1'b0;
    endtask

    task automatic test_random;
        logic [7:0] a;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bus.rinc = 1'($urandom_range(0, 1));
            if (bus.rvalid && bus.rinc) begin
                a = pidx[7:0];
                vectors++; if (bus.rdata !== mem[a]) begin miscompares++; $display("FAIL random_data[%0d]: got %0h expected %0h", pidx, bus.rdata, mem[a]); end
                pidx++;
            end
            if ($urandom_range(0, 2) == 0 && (wtot - pidx) < 250)
                set_w(wtot + $urandom_range(1, 3));
            tick();
        end
    endtask

    task automatic test_level_reset;
        bus.rinc = 1'b0;
        rrst_n = 1'b0;
        set_w(0);
        pidx = 0;
        tick();
        rrst_n = 1'b1;
        tick();
        set_w(6);
        tick();
        vectors++; if (bus.rlevel !== 9'd6 || bus.ralmost_empty !== 1'b0) begin miscompares++; $display("FAIL level6: got %0d ae=%0b expected 6 0", bus.rlevel, bus.ralmost_empty); end
        tick();
        tick();
        vectors++; if (bus.rlevel !== 9'd4 || bus.ralmost_empty !== 1'b1) begin miscompares++; $display("FAIL level4: got %0d ae=%0b expected 4 1", bus.rlevel, bus.ralmost_empty); end
        vectors++; if (bus.rvalid !== 1'b1 || bus.rdata !== mem[0] || bus.ren !== 1'b0) begin miscompares++; $display("FAIL level_buf: got v=%0b d=%0h ren=%0b expected 1 %0h 0", bus.rvalid, bus.rdata, bus.ren, mem[0]); end
        rrst_n = 1'b0;
        set_w(0);
        tick();
        vectors++; if (bus.rvalid !== 1'b0 || bus.rdata !== 8'h0 || bus.rptr !== 9'h0) begin miscompares++; $display("FAIL midreset: got v=%0b d=%0h rptr=%0h expected 0 0 0", bus.rvalid, bus.rdata, bus.rptr); end
        vectors++; if (bus.rempty !== 1'b1 || bus.rlevel !== 9'h0 || bus.ralmost_empty !== 1'b1) begin miscompares++; $display("FAIL midreset_flags: got e=%0b l=%0d ae=%0b expected 1 0 1", bus.rempty, bus.rlevel, bus.ralmost_empty); end
        rrst_n = 1'b1;
        bus.rinc = 1'b1;
        repeat (3) begin
            tick();
            vectors++; if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL dropped_word: got rvalid=%0b expected 0", bus.rvalid); end
        end
        bus.rinc = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        wtot = 0;
        pidx = 0;
        rrst_n = 1'b0;
        bus.rinc = 1'b0;
        bus.rq2_wptr = '0;
        bus.rdata_mem = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        @(negedge rclk);
        test_reset();
        test_single();
        test_stream_wrap();
        test_drain();
        test_stall();
        test_pop_empty();
        test_random();
        test_drain();
        test_level_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
